// File: rtl/bitfusion_pkg.sv
// Shared BitFusion definitions: input-bitwidth encodings, weight-fetch
// sequencer state enum and the bitwidth -> last-phase helper.
package bitfusion_pkg;

  localparam logic [1:0] BW_8B = 2'b00;
  localparam logic [1:0] BW_4B = 2'b01;
  localparam logic [1:0] BW_2B = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } wfs_state_e;

  // Index of the last mux phase for a word; 2'b11 is treated as 2-bit mode.
  function automatic logic [1:0] last_phase(input logic [1:0] bw);
    case (bw)
      BW_8B:   return 2'd0;
      BW_4B:   return 2'd1;
      BW_2B:   return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/weight_fetch_sequencer.sv
// Weight fetch sequencer: reads num_words 32-bit words from the weight
// buffer starting at BASE_ADDR and presents each word to the weight mux
// for 1/2/4 phases depending on the latched input bitwidth.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   start, num_words,
//   input_bitwidth                run launch (sampled only in IDLE)
//   buf_rd_req/addr/valid/data    weight-buffer read interface
//   word_q, phase, bw_q           weight mux selection
//   out_valid, out_ready          selection handshake with the PE array
//   busy, done                    run status / end-of-run pulse
//   stall_cnt                     only with WFS_STALL_CNT_EN defined:
//                                 saturating count of out_valid && !out_ready
module weight_fetch_sequencer
  import bitfusion_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [1:0]        input_bitwidth,
  output logic              buf_rd_req,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic              buf_rd_valid,
  input  logic [31:0]       buf_rd_data,
  output logic [31:0]       word_q,
  output logic [1:0]        phase,
  output logic [1:0]        bw_q,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef WFS_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              busy,
  output logic              done
);

  wfs_state_e        r_state;
  logic [ADDR_W-1:0] r_num_words;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_word;
  logic [1:0]        r_phase;
  logic [1:0]        r_bw;
  logic              r_rd_req;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;

  logic [1:0]        w_last_phase;
  logic [ADDR_W-1:0] w_count_nxt;

  assign w_last_phase = last_phase(r_bw);
  assign w_count_nxt  = r_count + ADDR_W'(1);

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_num_words <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_word      <= '0;
      r_phase     <= '0;
      r_bw        <= '0;
      r_rd_req    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_words <= num_words;
            r_bw        <= input_bitwidth;
            r_addr      <= ADDR_W'(BASE_ADDR);
            r_count     <= '0;
            r_phase     <= '0;
            r_busy      <= 1'b1;
            if (num_words != '0) begin
              r_state  <= ST_FETCH;
              r_rd_req <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (buf_rd_valid) begin
            r_word      <= buf_rd_data;
            r_phase     <= '0;
            r_rd_req    <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (r_phase == w_last_phase) begin
              // Word fully consumed: either finish or fetch the next one
              r_phase     <= '0;
              r_count     <= w_count_nxt;
              r_out_valid <= 1'b0;
              if (w_count_nxt == r_num_words) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_rd_req <= 1'b1;
                r_state  <= ST_FETCH;
              end
            end else begin
              r_phase <= r_phase + 2'd1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WFS_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating back-pressure counter, restarted by each accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign buf_rd_req  = r_rd_req;
  assign buf_rd_addr = r_addr;
  assign word_q      = r_word;
  assign phase       = r_phase;
  assign bw_q        = r_bw;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench for weight_fetch_sequencer. Inputs change and outputs are
// checked on the falling clock edge; the bench plays the weight buffer.
module tb_weight_fetch_sequencer;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] num_words;
  logic [1:0]        input_bitwidth;
  logic              buf_rd_req;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              buf_rd_valid;
  logic [31:0]       buf_rd_data;
  logic [31:0]       word_q;
  logic [1:0]        phase;
  logic [1:0]        bw_q;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef WFS_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_beats;

  weight_fetch_sequencer #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .num_words      (num_words),
    .input_bitwidth (input_bitwidth),
    .buf_rd_req     (buf_rd_req),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_valid   (buf_rd_valid),
    .buf_rd_data    (buf_rd_data),
    .word_q         (word_q),
    .phase          (phase),
    .bw_q           (bw_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
`ifdef WFS_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] nw, input logic [1:0] bw);
    start          = 1'b1;
    num_words      = nw;
    input_bitwidth = bw;
    tick();
    start          = 1'b0;
    input_bitwidth = ~bw;  // later changes must not affect the run
  endtask

  // Weight-buffer model: hold valid back for lat cycles, then return data.
  task automatic serve(input int lat, input logic [31:0] data, input logic [ADDR_W-1:0] exp_addr);
    check("fetch_req", 32'(buf_rd_req), 32'd1);
    check("fetch_addr", 32'(buf_rd_addr), 32'(exp_addr));
    check("fetch_no_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      tick();
      check("fetch_req_hold", 32'(buf_rd_req), 32'd1);
      check("fetch_addr_hold", 32'(buf_rd_addr), 32'(exp_addr));
    end
    buf_rd_valid = 1'b1;
    buf_rd_data  = data;
    tick();
    buf_rd_valid = 1'b0;
    buf_rd_data  = 32'hDEAD_BEEF;
    check("load_word", word_q, data);
    check("load_req_low", 32'(buf_rd_req), 32'd0);
  endtask

  // One accepted mux selection (out_ready is high).
  task automatic beat(input logic [1:0] ph, input logic [31:0] w, input logic [1:0] bw);
    check("beat_valid", 32'(out_valid), 32'd1);
    check("beat_phase", 32'(phase), 32'(ph));
    check("beat_word", word_q, w);
    check("beat_bw", 32'(bw_q), 32'(bw));
    check("beat_busy", 32'(busy), 32'd1);
    n_beats++;
    tick();
  endtask

  task automatic expect_done();
    check("done_pulse", 32'(done), 32'd1);
    check("done_no_valid", 32'(out_valid), 32'd0);
    check("done_no_req", 32'(buf_rd_req), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    num_words      = '0;
    input_bitwidth = 2'b00;
    buf_rd_valid   = 1'b0;
    buf_rd_data    = '0;
    out_ready      = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_req", 32'(buf_rd_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(buf_rd_addr), 32'd0);
    check("rst_word", word_q, 32'd0);
    reset_n = 1'b1;
    tick();

    // 8-bit mode, three words, one beat each
    do_start(10'd3, 2'b00);
    serve(1, 32'hAAAA_0001, 10'd0);
    beat(2'd0, 32'hAAAA_0001, 2'b00);
    serve(2, 32'hBBBB_0002, 10'd1);
    beat(2'd0, 32'hBBBB_0002, 2'b00);
    serve(1, 32'hCCCC_0003, 10'd2);
    beat(2'd0, 32'hCCCC_0003, 2'b00);
    expect_done();

    // 4-bit mode, single word, two phases, no second read
    do_start(10'd1, 2'b01);
    serve(1, 32'h4433_2211, 10'd0);
    beat(2'd0, 32'h4433_2211, 2'b01);
    beat(2'd1, 32'h4433_2211, 2'b01);
    expect_done();
    tick();
    check("bw01_no_second_read", 32'(buf_rd_req), 32'd0);

    // bw=11 behaves as 2-bit; back-pressure for 3 cycles on phase 2
    n_beats = 0;
    do_start(10'd2, 2'b11);
    serve(1, 32'h1234_5678, 10'd0);
    beat(2'd0, 32'h1234_5678, 2'b11);
    beat(2'd1, 32'h1234_5678, 2'b11);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_phase", 32'(phase), 32'd2);
      check("stall_word", word_q, 32'h1234_5678);
      check("stall_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    beat(2'd2, 32'h1234_5678, 2'b11);
    beat(2'd3, 32'h1234_5678, 2'b11);
    serve(1, 32'h9ABC_DEF0, 10'd1);
    for (int p = 0; p < 4; p++) beat(2'(p), 32'h9ABC_DEF0, 2'b11);
    check("bw11_beats", 32'(n_beats), 32'd8);
    expect_done();
`ifdef WFS_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 32'd3);
`endif

    // Zero-length run: done next cycle, never a read
    do_start(10'd0, 2'b00);
    check("zero_req", 32'(buf_rd_req), 32'd0);
    check("zero_busy", 32'(busy), 32'd1);
    expect_done();
    check("zero_req_after", 32'(buf_rd_req), 32'd0);

    // Reset mid-stream at phase 1
    do_start(10'd2, 2'b10);
    serve(1, 32'h5555_AAAA, 10'd0);
    beat(2'd0, 32'h5555_AAAA, 2'b10);
    check("abort_pre_phase", 32'(phase), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_phase", 32'(phase), 32'd0);
    check("abort_word", word_q, 32'd0);
    check("abort_bw", 32'(bw_q), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_req", 32'(buf_rd_req), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_no_done", 32'(done), 32'd0);
    do_start(10'd1, 2'b00);
    serve(1, 32'h0BAD_F00D, 10'd0);
    beat(2'd0, 32'h0BAD_F00D, 2'b00);
    expect_done();

    // Slow buffer (5 cycles) with a stray start while busy
    do_start(10'd1, 2'b00);
    check("slow_req", 32'(buf_rd_req), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start     = 1'b1;
        num_words = 10'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      check("slow_req_hold", 32'(buf_rd_req), 32'd1);
      check("slow_addr_hold", 32'(buf_rd_addr), 32'd0);
    end
    start        = 1'b0;
    buf_rd_valid = 1'b1;
    buf_rd_data  = 32'hFEED_0005;
    tick();
    buf_rd_valid = 1'b0;
    beat(2'd0, 32'hFEED_0005, 2'b00);
    expect_done();
    tick();
    check("slow_idle_req", 32'(buf_rd_req), 32'd0);
    check("slow_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_fetch_sequencer.md
WEIGHT_FETCH_SEQUENCER -- requirements
Module: weight_fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, weight-buffer word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first buffer word address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching a fetch run.
REQ-006 SHALL have port num_words  input  ADDR_W  number of 32-bit words in the run.
REQ-007 SHALL have port input_bitwidth  input  2  input precision: 00=8b, 01=4b, 10/11=2b.
REQ-008 SHALL have port buf_rd_req  output  1  weight-buffer read request.
REQ-009 SHALL have port buf_rd_addr  output  ADDR_W  weight-buffer read address.
REQ-010 SHALL have port buf_rd_valid  input  1  read data valid, returned 1..N cycles after request.
REQ-011 SHALL have port buf_rd_data  input  32  read data.
REQ-012 SHALL have port word_q  output  32  held word, drives the weight mux buffer input.
REQ-013 SHALL have port phase  output  2  drives the weight mux state select.
REQ-014 SHALL have port bw_q  output  2  latched bitwidth, drives the weight mux input_bitwidth.
REQ-015 SHALL have port out_valid  output  1  word_q/phase/bw_q present a valid mux selection.
REQ-016 SHALL have port out_ready  input  1  downstream PE array accepts the current selection.
REQ-017 SHALL have port busy  output  1  high outside IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at run end.

Function
REQ-019 SHALL implement FSM IDLE, FETCH, STREAM, DONE.
REQ-020 IDLE: start=1 SHALL latch num_words and input_bitwidth (bw_q), set buf_rd_addr=BASE_ADDR, word count=0; go to FETCH if num_words!=0, else DONE.
REQ-021 start SHALL be ignored outside IDLE; input_bitwidth changes while busy SHALL have no effect.
REQ-022 FETCH: buf_rd_req SHALL be 1 with stable buf_rd_addr until buf_rd_valid is sampled high; that cycle SHALL load word_q, set phase=0, and go to STREAM.
REQ-023 buf_rd_valid outside FETCH SHALL be ignored.
REQ-024 phases per word SHALL be 1 (bw_q=00), 2 (01), 4 (10 or 11); bw_q=11 SHALL behave exactly as 10.
REQ-025 STREAM: out_valid SHALL be 1; phase, word_q and bw_q SHALL remain stable until out_valid&&out_ready.
REQ-026 On handshake at a non-last phase, phase SHALL increment by 1.
REQ-027 On handshake at the last phase, the word count SHALL increment and phase SHALL return to 0; if count+1==num_words go to DONE, else buf_rd_addr+1 (modulo 2^ADDR_W) and go to FETCH.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-029 Minimum per-word cost SHALL be 1 fetch cycle + phases cycles (no fetch/stream overlap).

Reset
REQ-030 reset_n low SHALL immediately force IDLE, and buf_rd_req, out_valid, busy, done, phase, bw_q, word_q, buf_rd_addr and counters to 0, including mid-run; no done pulse on abort.

Configuration
REQ-031 With WFS_STALL_CNT_EN defined, SHALL add output stall_cnt (32b) counting cycles where out_valid=1 and out_ready=0, cleared at reset and on accepted start, saturating at all-ones.
REQ-032 Without WFS_STALL_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Bitwidth encodings (BW_8B, BW_4B, BW_2B) and FSM state enum SHALL live in shared package bitfusion_pkg.
REQ-034 A phase-count helper (bitwidth -> last-phase index) SHALL be a package function; no sub-module.
REQ-035 Top-level integration SHALL connect word_q/phase/bw_q directly to the existing weight mux register.

Verification
REQ-036 bw=00, num_words=3, data A,B,C, out_ready=1 -> three out_valid beats phase=0, addresses 0,1,2, done after third beat.
REQ-037 bw=01, num_words=1, data 0x44332211 -> beats phase 0,1, then done; no second read.
REQ-038 bw=11, num_words=2, out_ready low 3 cycles on phase 2 -> phase/word_q held 3 cycles, 8 beats total, stall_cnt=3 with macro.
REQ-039 num_words=0 start -> done one cycle later, buf_rd_req never asserted.
REQ-040 reset_n low during STREAM phase 1 -> all outputs 0 same cycle, IDLE, no done; new start runs cleanly.
REQ-041 buf_rd_valid delayed 5 cycles, start pulsed while busy -> buf_rd_addr stable, start ignored, run completes normally.
